// File: rtl/pkt_bufid_distributor.sv
// Prefetches free buffer IDs from the free-bufid FIFO into one offer slot per
// network input port. When both ports are empty, they are served round-robin.
module pkt_bufid_distributor #(
    parameter int BUFID_W = 9
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               i_dist_enable,
    output logic               o_free_bufid_fifo_rd,
    input  logic [BUFID_W-1:0] iv_free_bufid_fifo_rdata,
    input  logic               i_free_bufid_fifo_empty,
    output logic               o_pkt_bufid_wr_p0,
    output logic               o_pkt_bufid_wr_p1,
    output logic [BUFID_W-1:0] ov_pkt_bufid_p0,
    output logic [BUFID_W-1:0] ov_pkt_bufid_p1,
    input  logic               i_pkt_bufid_ack_p0,
    input  logic               i_pkt_bufid_ack_p1,
    output logic               o_bufid_starve_pulse,
    output logic [1:0]         ov_dist_state
);
    // state | meaning
    // IDLE  | wait for a needy port and a non-empty FIFO; grant a port and strobe rd
    // RD    | FIFO read in flight
    // LAT   | FIFO data valid; load it into the granted slot
    // 3     | unused; returns to IDLE
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD     = 2'd1,
        ST_LAT    = 2'd2,
        ST_UNUSED = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 rd_q, rd_d;
    logic                 rr_ptr_q, rr_ptr_d;
    logic                 gnt_q, gnt_d;
    logic                 wr_p0_q, wr_p0_d;
    logic                 wr_p1_q, wr_p1_d;
    logic [BUFID_W-1:0]   bufid_p0_q, bufid_p0_d;
    logic [BUFID_W-1:0]   bufid_p1_q, bufid_p1_d;
    logic                 starve_q, starve_d;
    logic                 starve_cond_q, starve_cond_d;
    logic                 need_p0, need_p1, grant_ok, gnt_sel;

    assign need_p0  = ~wr_p0_q;
    assign need_p1  = ~wr_p1_q;
    assign grant_ok = i_dist_enable & ~i_free_bufid_fifo_empty & (need_p0 | need_p1);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant_ok) state_d = ST_RD;
            ST_RD:   state_d = ST_LAT;
            ST_LAT:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        // gnt_sel: 0 = p0, 1 = p1; a lone needy port wins outright
        gnt_sel    = (need_p0 & need_p1) ? rr_ptr_q : need_p1;
        rd_d       = 1'b0;
        gnt_d      = gnt_q;
        rr_ptr_d   = rr_ptr_q;
        if (state_q == ST_IDLE && grant_ok) begin
            rd_d     = 1'b1;
            gnt_d    = gnt_sel;
            rr_ptr_d = ~gnt_sel;
        end

        wr_p0_d    = wr_p0_q & ~i_pkt_bufid_ack_p0;
        wr_p1_d    = wr_p1_q & ~i_pkt_bufid_ack_p1;
        bufid_p0_d = bufid_p0_q;
        bufid_p1_d = bufid_p1_q;
        if (state_q == ST_LAT) begin
            if (gnt_q) begin
                wr_p1_d    = 1'b1;
                bufid_p1_d = iv_free_bufid_fifo_rdata;
            end else begin
                wr_p0_d    = 1'b1;
                bufid_p0_d = iv_free_bufid_fifo_rdata;
            end
        end

        starve_cond_d = (need_p0 | need_p1) & i_free_bufid_fifo_empty & i_dist_enable;
        starve_d      = starve_cond_d & ~starve_cond_q;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rd_q          <= 1'b0;
            rr_ptr_q      <= 1'b0;
            gnt_q         <= 1'b0;
            wr_p0_q       <= 1'b0;
            wr_p1_q       <= 1'b0;
            bufid_p0_q    <= '0;
            bufid_p1_q    <= '0;
            starve_q      <= 1'b0;
            starve_cond_q <= 1'b0;
        end else begin
            rd_q          <= rd_d;
            rr_ptr_q      <= rr_ptr_d;
            gnt_q         <= gnt_d;
            wr_p0_q       <= wr_p0_d;
            wr_p1_q       <= wr_p1_d;
            bufid_p0_q    <= bufid_p0_d;
            bufid_p1_q    <= bufid_p1_d;
            starve_q      <= starve_d;
            starve_cond_q <= starve_cond_d;
        end
    end

    assign o_free_bufid_fifo_rd = rd_q;
    assign o_pkt_bufid_wr_p0    = wr_p0_q;
    assign o_pkt_bufid_wr_p1    = wr_p1_q;
    assign ov_pkt_bufid_p0      = bufid_p0_q;
    assign ov_pkt_bufid_p1      = bufid_p1_q;
    assign o_bufid_starve_pulse = starve_q;
    assign ov_dist_state        = state_q;

endmodule

// File: tb/tb_pkt_bufid_distributor.sv
// Bench for pkt_bufid_distributor: behavioural FIFO, per-cycle reference model
// compare, and directed scenarios with hand-computed expectations.
module tb_pkt_bufid_distributor;
    localparam int W = 9;

    logic         clk_sys = 1'b0;
    logic         reset_n;
    logic         en;
    logic         fifo_rd;
    logic [W-1:0] fifo_rdata;
    logic         fifo_empty;
    logic         wr_p0, wr_p1;
    logic [W-1:0] id_p0, id_p1;
    logic         ack_p0, ack_p1;
    logic         starve;
    logic [1:0]   dist_state;

    int n_checks = 0;
    int n_fail   = 0;
    int rd_cnt   = 0;
    int starve_cnt = 0;

    pkt_bufid_distributor #(.BUFID_W(W)) dut (
        .clk_sys                  (clk_sys),
        .reset_n                  (reset_n),
        .i_dist_enable            (en),
        .o_free_bufid_fifo_rd     (fifo_rd),
        .iv_free_bufid_fifo_rdata (fifo_rdata),
        .i_free_bufid_fifo_empty  (fifo_empty),
        .o_pkt_bufid_wr_p0        (wr_p0),
        .o_pkt_bufid_wr_p1        (wr_p1),
        .ov_pkt_bufid_p0          (id_p0),
        .ov_pkt_bufid_p1          (id_p1),
        .i_pkt_bufid_ack_p0       (ack_p0),
        .i_pkt_bufid_ack_p1       (ack_p1),
        .o_bufid_starve_pulse     (starve),
        .ov_dist_state            (dist_state)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Free-bufid FIFO: read sampled mid-cycle, data/empty update just after the edge.
    logic [W-1:0] fifo_q[$];
    logic         rd_seen = 1'b0;

    always @(negedge clk_sys) begin
        rd_seen = fifo_rd;
        if (fifo_rd) rd_cnt++;
        if (starve) starve_cnt++;
    end

    always @(posedge clk_sys) begin
        #1;
        if (rd_seen) begin
            if (fifo_q.size() == 0) begin
                chk("fifo_underflow", 32'd1, 32'd0);
            end else begin
                fifo_rdata = fifo_q.pop_front();
            end
        end
        fifo_empty = (fifo_q.size() == 0);
    end

    task automatic fifo_push(input logic [W-1:0] v);
        fifo_q.push_back(v);
        fifo_empty = 1'b0;
    endtask

    task automatic fifo_clear();
        fifo_q.delete();
        fifo_empty = 1'b1;
    endtask

    // Reference model: slots, one outstanding read with its age, round-robin pointer.
    logic         m_wr[2];
    logic [W-1:0] m_id[2];
    int           m_age;
    int           m_gnt;
    int           m_rr;
    logic         m_rd, m_starve, m_prev;

    task automatic model_reset();
        m_wr[0] = 1'b0; m_wr[1] = 1'b0;
        m_id[0] = '0;   m_id[1] = '0;
        m_age = 0; m_gnt = 0; m_rr = 0;
        m_rd = 1'b0; m_starve = 1'b0; m_prev = 1'b0;
    endtask

    task automatic model_step();
        logic need[2];
        logic ack[2];
        logic cond;
        need[0] = !m_wr[0];
        need[1] = !m_wr[1];
        ack[0]  = ack_p0;
        ack[1]  = ack_p1;
        cond    = (need[0] || need[1]) && fifo_empty && en;
        m_starve = cond && !m_prev;
        m_prev   = cond;
        for (int p = 0; p < 2; p++)
            if (ack[p]) m_wr[p] = 1'b0;
        if (m_age == 2) begin
            m_wr[m_gnt] = 1'b1;
            m_id[m_gnt] = fifo_rdata;
        end
        m_rd = 1'b0;
        if (m_age == 0) begin
            if (en && !fifo_empty && (need[0] || need[1])) begin
                if (need[0] && need[1]) m_gnt = m_rr;
                else                    m_gnt = need[0] ? 0 : 1;
                m_rr  = 1 - m_gnt;
                m_rd  = 1'b1;
                m_age = 1;
            end
        end else begin
            m_age = (m_age + 1) % 3;
        end
    endtask

    always @(negedge clk_sys) begin
        if (!reset_n) model_reset();
        chk("m_rd",     {31'd0, fifo_rd}, {31'd0, m_rd});
        chk("m_wr_p0",  {31'd0, wr_p0},   {31'd0, m_wr[0]});
        chk("m_wr_p1",  {31'd0, wr_p1},   {31'd0, m_wr[1]});
        chk("m_id_p0",  {23'd0, id_p0},   {23'd0, m_id[0]});
        chk("m_id_p1",  {23'd0, id_p1},   {23'd0, m_id[1]});
        chk("m_starve", {31'd0, starve},  {31'd0, m_starve});
        chk("m_state",  {30'd0, dist_state}, m_age);
        if (reset_n) model_step();
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #2;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0;
        logic [W-1:0] f;
        logic reached;
        reset_n = 1'b0; en = 1'b1; ack_p0 = 1'b0; ack_p1 = 1'b0;
        fifo_rdata = '0; fifo_empty = 1'b1;
        model_reset();

        // Startup fill from 5,6,7
        fifo_push(9'd5); fifo_push(9'd6); fifo_push(9'd7);
        repeat (2) @(posedge clk_sys);
        #2;
        chk("rst_wr_p0", {31'd0, wr_p0}, 32'd0);
        chk("rst_state", {30'd0, dist_state}, 32'd0);
        reset_n = 1'b1;
        tick(1);
        chk("t1_rd_high", {31'd0, fifo_rd}, 32'd1);
        chk("t1_state_rd", {30'd0, dist_state}, 32'd1);
        tick(1);
        chk("t1_state_lat", {30'd0, dist_state}, 32'd2);
        chk("t1_wr_p0_c2", {31'd0, wr_p0}, 32'd0);
        tick(1);
        chk("t1_wr_p0_c3", {31'd0, wr_p0}, 32'd1);
        chk("t1_id_p0", {23'd0, id_p0}, 32'd5);
        tick(2);
        chk("t1_wr_p1_c5", {31'd0, wr_p1}, 32'd0);
        tick(1);
        chk("t1_wr_p1_c6", {31'd0, wr_p1}, 32'd1);
        chk("t1_id_p1", {23'd0, id_p1}, 32'd6);
        tick(5);
        chk("t1_rd_count", rd_cnt, 32'd2);
        chk("t1_fifo_left", fifo_q.size(), 32'd1);
        f = fifo_q[0];
        chk("t1_fifo_head", {23'd0, f}, 32'd7);

        // Ack p1 then p0 on consecutive edges, FIFO 10,11
        fifo_clear(); fifo_push(9'd10); fifo_push(9'd11);
        tick(1);
        ack_p1 = 1'b1;
        tick(1);
        ack_p1 = 1'b0; ack_p0 = 1'b1;
        chk("t2_wr_p1_fall", {31'd0, wr_p1}, 32'd0);
        chk("t2_wr_p0_hold", {31'd0, wr_p0}, 32'd1);
        tick(1);
        ack_p0 = 1'b0;
        chk("t2_wr_p0_fall", {31'd0, wr_p0}, 32'd0);
        tick(2);
        chk("t2_wr_p1_refill", {31'd0, wr_p1}, 32'd1);
        chk("t2_id_p1", {23'd0, id_p1}, 32'd10);
        chk("t2_wr_p0_wait", {31'd0, wr_p0}, 32'd0);
        tick(3);
        chk("t2_wr_p0_refill", {31'd0, wr_p0}, 32'd1);
        chk("t2_id_p0", {23'd0, id_p0}, 32'd11);
        tick(3);

        // Both acked together with rr at p1, twice
        for (int r = 0; r < 2; r++) begin
            fifo_push(9'(12 + 2 * r)); fifo_push(9'(13 + 2 * r));
            tick(1);
            ack_p0 = 1'b1; ack_p1 = 1'b1;
            tick(1);
            ack_p0 = 1'b0; ack_p1 = 1'b0;
            chk("t3_both_fall", {30'd0, wr_p1, wr_p0}, 32'd0);
            tick(3);
            chk("t3_p1_first", {30'd0, wr_p1, wr_p0}, 32'd2);
            chk("t3_id_p1", {23'd0, id_p1}, 32'(12 + 2 * r));
            tick(3);
            chk("t3_p0_second", {30'd0, wr_p1, wr_p0}, 32'd3);
            chk("t3_id_p0", {23'd0, id_p0}, 32'(13 + 2 * r));
            tick(2);
        end

        // Starvation with empty FIFO, then refill
        starve_cnt = 0; rd0 = rd_cnt;
        ack_p0 = 1'b1;
        tick(1);
        ack_p0 = 1'b0;
        tick(6);
        chk("t4_one_starve", starve_cnt, 32'd1);
        chk("t4_no_rd", rd_cnt - rd0, 32'd0);
        chk("t4_p0_empty", {31'd0, wr_p0}, 32'd0);
        fifo_push(9'd20); fifo_push(9'd21);
        tick(3);
        chk("t4_p0_refill", {31'd0, wr_p0}, 32'd1);
        chk("t4_id_p0", {23'd0, id_p0}, 32'd20);
        tick(3);
        chk("t4_no_repeat", starve_cnt, 32'd1);

        // Enable dropped while a read is in flight
        fifo_clear(); fifo_push(9'd30); fifo_push(9'd31);
        rd0 = rd_cnt;
        ack_p0 = 1'b1;
        tick(1);
        ack_p0 = 1'b0;
        tick(1);
        chk("t5_rd_issued", {31'd0, fifo_rd}, 32'd1);
        en = 1'b0; ack_p1 = 1'b1;
        tick(1);
        ack_p1 = 1'b0;
        chk("t5_p1_fall", {31'd0, wr_p1}, 32'd0);
        tick(1);
        chk("t5_inflight_load", {31'd0, wr_p0}, 32'd1);
        chk("t5_id_p0", {23'd0, id_p0}, 32'd30);
        tick(6);
        chk("t5_rd_once", rd_cnt - rd0, 32'd1);
        chk("t5_p1_still_empty", {31'd0, wr_p1}, 32'd0);
        en = 1'b1;
        tick(3);
        chk("t5_p1_refill", {31'd0, wr_p1}, 32'd1);
        chk("t5_id_p1", {23'd0, id_p1}, 32'd31);
        tick(2);

        // Asynchronous reset during LAT
        fifo_push(9'd40);
        ack_p0 = 1'b1;
        tick(1);
        ack_p0 = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (dist_state == 2'd2) begin
                reached = 1'b1;
                break;
            end
            tick(1);
        end
        chk("t6_lat_reached", {31'd0, reached}, 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_rd", {31'd0, fifo_rd}, 32'd0);
        chk("t6_rst_wr", {30'd0, wr_p1, wr_p0}, 32'd0);
        chk("t6_rst_id_p0", {23'd0, id_p0}, 32'd0);
        chk("t6_rst_id_p1", {23'd0, id_p1}, 32'd0);
        chk("t6_rst_starve", {31'd0, starve}, 32'd0);
        chk("t6_rst_state", {30'd0, dist_state}, 32'd0);
        tick(1);
        reset_n = 1'b1;
        tick(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
